// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, a registered result and status flags.
// MUL runs as an iterative shift-add over WIDTH cycles and stalls the input side meanwhile.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                 state;
  logic [SHW-1:0]         cnt;
  logic [WIDTH-1:0]       acc;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SHW-1:0]          sh;
  logic [WIDTH:0]          sum_c;
  logic [WIDTH:0]          diff_c;
  logic [WIDTH-1:0]        res_c;
  logic                    carry_c;
  logic                    ovf_c;
  logic                    err_c;
  logic                    is_mul;
  logic [WIDTH-1:0]        acc_next;

  // Flag vector layout: {err, neg, zero, carry, ovf}
  function automatic logic [4:0] pack_flags(input logic [WIDTH-1:0] r, input logic err,
                                            input logic carry, input logic ovf);
    return {err, r[WIDTH-1], (r == '0), carry, ovf};
  endfunction

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign is_mul   = ENABLE_MUL && (in_op == 4'd10);

  // Stage p0: single-cycle evaluation straight from the operand inputs
  always_comb begin
    a_s     = in_1;
    b_s     = in_2;
    sh      = in_2[SHW-1:0];
    sum_c   = {1'b0, in_1} + {1'b0, in_2};
    diff_c  = {1'b0, in_1} - {1'b0, in_2};
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    err_c   = 1'b0;
    case (in_op)
      4'd0: begin
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (res_c[WIDTH-1] != a_s[WIDTH-1]);
      end
      4'd1: begin
        res_c   = diff_c[WIDTH-1:0];
        carry_c = diff_c[WIDTH];
        ovf_c   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (res_c[WIDTH-1] != a_s[WIDTH-1]);
      end
      4'd2: res_c = in_1 & in_2;
      4'd3: res_c = in_1 | in_2;
      4'd4: res_c = in_1 ^ in_2;
      4'd5: res_c = $unsigned(a_s >>> sh);
      4'd6: res_c = in_1 >> sh;
      4'd7: res_c = in_1 << sh;
      4'd8: res_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd9: res_c = {{(WIDTH-1){1'b0}}, (in_1 < in_2)};
      // MUL results come from the iterative path; this only flags it when disabled
      4'd10: err_c = !ENABLE_MUL;
      default: err_c = 1'b1;
    endcase
  end

  assign acc_next = acc + (mul_b[cnt] ? (mul_a << cnt) : '0);

  // Stage p1: result register, handshake control and multiplier iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      cnt        <= '0;
      acc        <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (is_mul) begin
              mul_a <= in_1;
              mul_b <= in_2;
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              out_result <= res_c;
              out_flags  <= pack_flags(res_c, err_c, carry_c, ovf_c);
              out_valid  <= 1'b1;
            end
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            out_result <= acc_next;
            out_flags  <= pack_flags(acc_next, 1'b0, 1'b0, 1'b0);
            out_valid  <= 1'b1;
            state      <= IDLE;
          end else begin
            acc <= acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): expected results are queued at input accept
// and popped by an independent monitor whenever a result is consumed.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_1;
  logic [W-1:0]  in_2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [4:0]    out_flags;

  alu_seq #(.WIDTH(W), .ENABLE_MUL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_1(in_1), .in_2(in_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [36:0] sb[$];
  int          pop_cyc[$];
  logic        use_exp = 1'b0;
  logic [36:0] exp_val = '0;
  logic        rand_ready = 1'b0;
  logic        hold_v = 1'b0;
  logic [36:0] hold_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {flags{err,neg,zero,carry,ovf}, result} from plain integer arithmetic
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, full;
    longint      sa, sb, s;
    logic [31:0] r;
    logic        c, v, e;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; e = 1'b0; r = '0;
    case (op)
      4'd0: begin full = ua + ub; r = full[31:0]; c = full[32]; s = sa + sb; v = (s > MAXS) || (s < MINS); end
      4'd1: begin r = a - b; c = (ua < ub); s = sa - sb; v = (s > MAXS) || (s < MINS); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = $unsigned($signed(a) >>> b[4:0]);
      4'd6: r = a >> b[4:0];
      4'd7: r = a << b[4:0];
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd10: begin full = ua * ub; r = full[31:0]; end
      default: e = 1'b1;
    endcase
    return {e, r[31], (r == 32'd0), c, v, r};
  endfunction

  // Monitor: pushes expectations on input transfers, pops on output transfers
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (in_valid && in_ready)
        sb.push_back(use_exp ? exp_val : model(in_op, in_1, in_2));
      if (hold_v)
        check("hold_stable", {27'b0, out_valid, out_flags, out_result}, {27'b0, 1'b1, hold_val});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h, want no result", {out_flags, out_result});
        end else begin
          check("result", {27'b0, out_flags, out_result}, {27'b0, sb.pop_front()});
        end
        pop_cyc.push_back(cyc);
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_flags, out_result};
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic took;
    n = 0;
    in_valid = 1'b1; in_op = op; in_1 = a; in_2 = b;
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!took && n < 200);
    if (!took) check("issue_timeout", 64'(n), 64'd0);
    in_valid = 1'b0;
    in_op = $urandom(); in_1 = $urandom(); in_2 = $urandom();
  endtask

  task automatic dir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic [4:0] f);
    use_exp = 1'b1;
    exp_val = {f, r};
    issue(op, a, b);
    use_exp = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int k;
    int base;
    logic seen;
    logic rdy_seen;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_1 = '0; in_2 = '0; out_ready = 1'b1;
    step(3);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_result", {27'b0, out_flags, out_result}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'b0, in_ready}, 64'd1);

    // Arithmetic and compare
    dir(4'd0, 32'd128, 32'd2, 32'd130, 5'b00000);
    dir(4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 5'b01001);
    dir(4'd1, 32'd2, 32'd2, 32'd0, 5'b00100);
    dir(4'd1, 32'd1, 32'd2, 32'hFFFFFFFF, 5'b01010);
    dir(4'd8, 32'hFFFFFFFF, 32'd1, 32'd1, 5'b00000);
    dir(4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 5'b00100);
    // Shifts, upper amount bits ignored
    for (int i = 0; i < 2; i++) begin
      dir(4'd5, 32'h8000000F, (i == 0) ? 32'd2 : 32'd34, 32'hE0000003, 5'b01000);
      dir(4'd6, 32'h8000000F, (i == 0) ? 32'd2 : 32'd34, 32'h20000003, 5'b00000);
      dir(4'd7, 32'h8000000F, (i == 0) ? 32'd2 : 32'd34, 32'h0000003C, 5'b00000);
    end
    step(3);

    // MUL latency and input stall
    dir(4'd10, 32'd1234, 32'd5678, 32'h006AE9BC, 5'b00000);
    k = 0; rdy_seen = 1'b0;
    while (!out_valid && k < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check("mul_latency", 64'(k), 64'd32);
    check("mul_in_ready_low", {63'b0, rdy_seen}, 64'd0);
    step(2);

    // Backpressure hold, then back-to-back XORs
    out_ready = 1'b0;
    dir(4'd0, 32'd5, 32'd6, 32'd11, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      step(1);
    end
    base = pop_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) issue(4'd4, $urandom(), $urandom());
    step(3);
    check("b2b_count", 64'(pop_cyc.size() - base), 64'd5);
    if (pop_cyc.size() >= 4)
      check("b2b_consecutive", 64'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-4]), 64'd3);

    // Reset in the middle of a multiply
    issue(4'd10, $urandom(), $urandom());
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midmul_rst_valid", {63'b0, out_valid}, 64'd0);
    check("midmul_rst_ready", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      step(1);
    end
    check("no_result_after_rst", {63'b0, seen}, 64'd0);
    dir(4'd15, 32'h1234, 32'h5678, 32'd0, 5'b10100);
    step(2);

    // Randomized traffic against the model, with random backpressure and gaps
    rand_ready = 1'b1;
    for (int t = 0; t < 250; t++) begin
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val());
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      step(1);
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
